id_ex_latch: RTL and testbench

Decode/execute pipeline register for the five-stage MIPS core. It captures the decoded instruction from ID and presents it to EX one cycle later. Its source/destination register fields drive the forwarding unit's read/write address inputs. It also detects load-use hazards, inserting a single bubble and requesting an upstream stall, and it honours branch flushes and global pipeline holds.

---
 rtl/id_ex_latch.sv | 135 +++++++++++++
 tb/tb_id_ex_latch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// id_ex_latch: decode/execute pipeline register for the five-stage MIPS core.
// Captures the decoded ID instruction and presents it to EX one cycle later.
// It detects load-use hazards, inserting one bubble and asking upstream to
// stall. It honours branch flushes and global holds (ex_en low).
// Optional feature macro: ID_EX_PERF_EN adds bubble/flush performance counters.
module id_ex_latch (
    input  logic        CLK,
    input  logic        RST,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_wsel,
    input  logic [31:0] id_rdat1,
    input  logic [31:0] id_rdat2,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc4,
    input  logic [15:0] id_ctrl,
    input  logic        id_memread,
    input  logic        id_regwrite,
    input  logic        ex_en,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wsel,
    output logic [31:0] ex_rdat1,
    output logic [31:0] ex_rdat2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic [15:0] ex_ctrl,
    output logic        ex_memread,
    output logic        ex_regwrite,
    output logic        lu_stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic        r_exValid;
    logic [4:0]  r_exRs;
    logic [4:0]  r_exRt;
    logic [4:0]  r_exWsel;
    logic [31:0] r_exRdat1;
    logic [31:0] r_exRdat2;
    logic [31:0] r_exImm;
    logic [31:0] r_exPc4;
    logic [15:0] r_exCtrl;
    logic        r_exMemread;
    logic        r_exRegwrite;

    logic w_luStall;
    logic w_clear;
    logic w_load;

    // A load in EX whose destination is a source of the ID instruction must
    // stall one cycle. Writes to $0 never create a real dependency.
    assign w_luStall = r_exValid & r_exMemread & (r_exWsel != 5'd0) & id_valid &
                       ((id_rs == r_exWsel) | (id_rt == r_exWsel));

    // Reset, flush and an enabled load-use stall all load a bubble (all zeros).
    // A hold (ex_en low) blocks only the stall bubble; flush and reset still act.
    assign w_clear = RST | flush | (ex_en & w_luStall);
    assign w_load  = ex_en & ~w_luStall;

    // Pipeline register: bubble takes priority over hold, hold over load.
    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_exValid    <= 1'b0;
            r_exRs       <= 5'd0;
            r_exRt       <= 5'd0;
            r_exWsel     <= 5'd0;
            r_exRdat1    <= 32'd0;
            r_exRdat2    <= 32'd0;
            r_exImm      <= 32'd0;
            r_exPc4      <= 32'd0;
            r_exCtrl     <= 16'd0;
            r_exMemread  <= 1'b0;
            r_exRegwrite <= 1'b0;
        end else if (w_load) begin
            r_exValid    <= id_valid;
            r_exRs       <= id_rs;
            r_exRt       <= id_rt;
            r_exWsel     <= id_wsel;
            r_exRdat1    <= id_rdat1;
            r_exRdat2    <= id_rdat2;
            r_exImm      <= id_imm;
            r_exPc4      <= id_pc4;
            r_exCtrl     <= id_ctrl;
            r_exMemread  <= id_memread;
            r_exRegwrite <= id_regwrite;
        end
    end

    assign ex_valid    = r_exValid;
    assign ex_rs       = r_exRs;
    assign ex_rt       = r_exRt;
    assign ex_wsel     = r_exWsel;
    assign ex_rdat1    = r_exRdat1;
    assign ex_rdat2    = r_exRdat2;
    assign ex_imm      = r_exImm;
    assign ex_pc4      = r_exPc4;
    assign ex_ctrl     = r_exCtrl;
    assign ex_memread  = r_exMemread;
    assign ex_regwrite = r_exRegwrite;
    assign lu_stall    = w_luStall;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubbleCnt;
    logic [31:0] r_flushCnt;

    // Saturating counters. Flushes are counted even during a hold; stall
    // bubbles are counted only when one is actually loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bubbleCnt <= 32'd0;
            r_flushCnt  <= 32'd0;
        end else begin
            if (flush && (r_flushCnt != 32'hFFFF_FFFF)) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
            if (!flush && ex_en && w_luStall && (r_bubbleCnt != 32'hFFFF_FFFF)) begin
                r_bubbleCnt <= r_bubbleCnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubbleCnt;
    assign flush_cnt  = r_flushCnt;
`else
    // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: scoreboard bench for id_ex_latch. A behavioural model of the
// EX register computes each expected state as stimulus is applied. That state is
// queued and compared after the clock edge, together with lu_stall and
// (with ID_EX_PERF_EN) the counters.
module tb_id_ex_latch;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wsel;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [15:0] ctrl;
        logic        memread;
        logic        regwrite;
    } exState_t;

    logic        CLK;
    logic        RST;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_wsel;
    logic [31:0] id_rdat1;
    logic [31:0] id_rdat2;
    logic [31:0] id_imm;
    logic [31:0] id_pc4;
    logic [15:0] id_ctrl;
    logic        id_memread;
    logic        id_regwrite;
    logic        ex_en;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_rdat1;
    logic [31:0] ex_rdat2;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc4;
    logic [15:0] ex_ctrl;
    logic        ex_memread;
    logic        ex_regwrite;
    logic        lu_stall;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    exState_t dutState;
    exState_t model;
    exState_t expState;
    exState_t scoreboard[$];
    logic [31:0] modelBubbles;
    logic [31:0] modelFlushes;
    int nCompared;
    int nMismatched;

    assign dutState = {ex_valid, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2,
                       ex_imm, ex_pc4, ex_ctrl, ex_memread, ex_regwrite};

    id_ex_latch dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_ctrl(id_ctrl), .id_memread(id_memread), .id_regwrite(id_regwrite),
        .ex_en(ex_en), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wsel(ex_wsel),
        .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_ctrl(ex_ctrl), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .lu_stall(lu_stall)
`ifdef ID_EX_PERF_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Free-running core clock, 10 time units per cycle.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic modelLu();
        return model.valid & model.memread & (model.wsel != 5'd0) & id_valid &
               ((id_rs == model.wsel) | (id_rt == model.wsel));
    endfunction

    task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] ws, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] im, input logic [31:0] pc, input logic [15:0] ct,
                            input logic mr, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_wsel = ws;
        id_rdat1 = d1; id_rdat2 = d2; id_imm = im; id_pc4 = pc;
        id_ctrl = ct; id_memread = mr; id_regwrite = rw;
    endtask

    // Advance one clock: the model's next state is queued before the edge.
    task automatic applyStimulus();
        exState_t nxt;
        logic lu;
        lu = modelLu();
        if (RST || flush) nxt = '0;
        else if (!ex_en) nxt = model;
        else if (lu) nxt = '0;
        else nxt = {id_valid, id_rs, id_rt, id_wsel, id_rdat1, id_rdat2,
                    id_imm, id_pc4, id_ctrl, id_memread, id_regwrite};
        if (RST) begin
            modelBubbles = 32'd0;
            modelFlushes = 32'd0;
        end else if (flush) begin
            if (modelFlushes != 32'hFFFF_FFFF) modelFlushes = modelFlushes + 32'd1;
        end else if (ex_en && lu) begin
            if (modelBubbles != 32'hFFFF_FFFF) modelBubbles = modelBubbles + 32'd1;
        end
        scoreboard.push_back(nxt);
        @(posedge CLK);
        #1;
        model = nxt;
    endtask

    task automatic test_reset();
        RST = 1'b1; flush = 1'b0; ex_en = 1'b1;
        setInstr(1'b1, 5'h1F, 5'h1F, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            expState = scoreboard.pop_front();
            nCompared++;
            if (dutState !== expState || dutState !== '0) begin
                nMismatched++;
                $display("[TB] FAIL reset_state: got %h expected %h", dutState, expState);
            end
        end
        nCompared++;
        if (lu_stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_lu_stall: got %b expected 0", lu_stall);
        end
`ifdef ID_EX_PERF_EN
        nCompared++;
        if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_counters: got %h/%h expected 0/0", bubble_cnt, flush_cnt);
        end
`endif
        RST = 1'b0;
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_rdat1 !== 32'hFFFF_FFFF) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_load: got %h expected %h", dutState, expState);
        end
    endtask

    task automatic test_passthrough();
        setInstr(1'b1, 5'd3, 5'd4, 5'd5, 32'h1234, 32'h5678, 32'h9, 32'h104, 16'hA5A5, 1'b0, 1'b1);
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_rs !== 5'd3 || ex_rt !== 5'd4 || ex_wsel !== 5'd5 ||
            ex_rdat1 !== 32'h1234 || ex_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL passthrough: got %h expected %h", dutState, expState);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] bubblesBefore;
        // lw $2 enters EX
        setInstr(1'b1, 5'd1, 5'd0, 5'd2, 32'h40, 32'h0, 32'h8, 32'h108, 16'h0011, 1'b1, 1'b1);
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState) begin
            nMismatched++;
            $display("[TB] FAIL lu_load_in_ex: got %h expected %h", dutState, expState);
        end
        bubblesBefore = modelBubbles;
        setInstr(1'b1, 5'd2, 5'd7, 5'd9, 32'hAA, 32'hBB, 32'hCC, 32'h10C, 16'h0022, 1'b0, 1'b1);
        #1;
        nCompared++;
        if (lu_stall !== 1'b1 || lu_stall !== modelLu()) begin
            nMismatched++;
            $display("[TB] FAIL lu_stall_assert: got %b expected 1", lu_stall);
        end
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_valid !== 1'b0 || ex_wsel !== 5'd0 || lu_stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL lu_bubble: got %h stall %b expected %h stall 0",
                     dutState, lu_stall, expState);
        end
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_rs !== 5'd2 || ex_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL lu_held_loads: got %h expected %h", dutState, expState);
        end
`ifdef ID_EX_PERF_EN
        nCompared++;
        if (bubble_cnt !== modelBubbles || bubble_cnt !== bubblesBefore + 32'd1) begin
            nMismatched++;
            $display("[TB] FAIL lu_bubble_cnt: got %h expected %h", bubble_cnt, modelBubbles);
        end
`endif
    endtask

    task automatic test_hold();
        exState_t held;
        held = model;
        ex_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setInstr(1'b1, 5'(i + 10), 5'(i + 11), 5'(i + 12), 32'(i * 7), 32'(i * 9),
                     32'(i), 32'h200 + 32'(i), 16'(i), 1'b0, 1'b1);
            applyStimulus();
            expState = scoreboard.pop_front();
            nCompared++;
            if (dutState !== expState || dutState !== held) begin
                nMismatched++;
                $display("[TB] FAIL hold_constant: got %h expected %h", dutState, expState);
            end
        end
        // lw $6 into EX, then hold with a dependent instruction in ID
        ex_en = 1'b1;
        setInstr(1'b1, 5'd0, 5'd0, 5'd6, 32'h1, 32'h2, 32'h3, 32'h300, 16'h0033, 1'b1, 1'b1);
        applyStimulus();
        void'(scoreboard.pop_front());
        held = model;
        ex_en = 1'b0;
        setInstr(1'b1, 5'd8, 5'd6, 5'd10, 32'h11, 32'h22, 32'h33, 32'h304, 16'h0044, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            nCompared++;
            if (lu_stall !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL hold_lu_stall: got %b expected 1", lu_stall);
            end
            applyStimulus();
            expState = scoreboard.pop_front();
            nCompared++;
            if (dutState !== expState || dutState !== held) begin
                nMismatched++;
                $display("[TB] FAIL hold_no_bubble: got %h expected %h", dutState, expState);
            end
        end
        ex_en = 1'b1;
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL hold_release_bubble: got %h expected %h", dutState, expState);
        end
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_rt !== 5'd6) begin
            nMismatched++;
            $display("[TB] FAIL hold_release_load: got %h expected %h", dutState, expState);
        end
    endtask

    task automatic test_flush();
        logic [31:0] bubblesBefore;
        logic [31:0] flushesBefore;
        flush = 1'b1;
        setInstr(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 32'h400, 16'h0055, 1'b0, 1'b1);
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_bubble: got %h expected %h", dutState, expState);
        end
        // lw $3 into EX, then flush with a dependent instruction
        flush = 1'b0;
        setInstr(1'b1, 5'd0, 5'd0, 5'd3, 32'h8, 32'h9, 32'hA, 32'h404, 16'h0066, 1'b1, 1'b1);
        applyStimulus();
        void'(scoreboard.pop_front());
        bubblesBefore = modelBubbles;
        flushesBefore = modelFlushes;
        flush = 1'b1;
        setInstr(1'b1, 5'd3, 5'd4, 5'd5, 32'hB, 32'hC, 32'hD, 32'h408, 16'h0077, 1'b0, 1'b1);
        #1;
        nCompared++;
        if (lu_stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL flush_lu_stall: got %b expected 1", lu_stall);
        end
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || dutState !== '0) begin
            nMismatched++;
            $display("[TB] FAIL flush_with_stall: got %h expected %h", dutState, expState);
        end
`ifdef ID_EX_PERF_EN
        nCompared++;
        if (flush_cnt !== flushesBefore + 32'd1 || bubble_cnt !== bubblesBefore) begin
            nMismatched++;
            $display("[TB] FAIL flush_counters: got %h/%h expected %h/%h",
                     flush_cnt, bubble_cnt, flushesBefore + 32'd1, bubblesBefore);
        end
`endif
        flush = 1'b0;
    endtask

    task automatic test_load_zero();
        setInstr(1'b1, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3, 32'h500, 16'h0088, 1'b1, 1'b1);
        applyStimulus();
        void'(scoreboard.pop_front());
        setInstr(1'b1, 5'd0, 5'd0, 5'd7, 32'h71, 32'h72, 32'h73, 32'h504, 16'h0099, 1'b0, 1'b1);
        #1;
        nCompared++;
        if (lu_stall !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL load_zero_stall: got %b expected 0", lu_stall);
        end
        applyStimulus();
        expState = scoreboard.pop_front();
        nCompared++;
        if (dutState !== expState || ex_wsel !== 5'd7 || ex_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL load_zero_loads: got %h expected %h", dutState, expState);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            RST   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            ex_en = ($urandom_range(0, 3) != 0);
            setInstr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                     16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            nCompared++;
            if (lu_stall !== modelLu()) begin
                nMismatched++;
                $display("[TB] FAIL random_lu_stall[%0d]: got %b expected %b", i, lu_stall, modelLu());
            end
            applyStimulus();
            expState = scoreboard.pop_front();
            nCompared++;
            if (dutState !== expState) begin
                nMismatched++;
                $display("[TB] FAIL random_state[%0d]: got %h expected %h", i, dutState, expState);
            end
`ifdef ID_EX_PERF_EN
            nCompared++;
            if (bubble_cnt !== modelBubbles || flush_cnt !== modelFlushes) begin
                nMismatched++;
                $display("[TB] FAIL random_counters[%0d]: got %h/%h expected %h/%h",
                         i, bubble_cnt, flush_cnt, modelBubbles, modelFlushes);
            end
`endif
        end
        RST = 1'b0; flush = 1'b0; ex_en = 1'b1;
    endtask

    // Test sequence followed by the summary line.
    initial begin
        nCompared = 0;
        nMismatched = 0;
        model = '0;
        modelBubbles = 32'd0;
        modelFlushes = 32'd0;
        RST = 1'b1; flush = 1'b0; ex_en = 1'b1;
        setInstr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        test_reset();
        test_passthrough();
        test_load_use();
        test_hold();
        test_flush();
        test_load_zero();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
